// File: rtl/serial_tx.sv
// ---------------------------------------------------------------------------
// serial_tx
// Pulls bytes from an upstream queue and shifts them out as asynchronous
// serial frames: one start bit (0), eight data bits LSB first, an optional
// even-parity bit, and one stop bit (1). Each bit lasts CLK_DIV clocks.
// After the stop bit a single GAP cycle pulses tx_done_out and lets the
// upstream queue occupancy settle before the next launch decision.
//
// Parameters
//   CLK_DIV    clocks per serial bit (2..255)
//   PARITY_EN  1 inserts an even-parity bit after the data bits, 0 omits it
//
// Ports
//   clock             system clock, rising edge
//   reset             asynchronous, active-high reset
//   len_in            upstream queue occupancy (0 = empty)
//   data_in           upstream queue head byte, valid when len_in != 0
//   tx_ready_in       downstream can accept a new frame
//   dequeue_out       one-cycle pop pulse to the upstream queue
//   serial_out        serial line, idles high
//   frame_active_out  high from the start bit through the last stop cycle
//   tx_done_out       one-cycle pulse when a frame completes
//   sent_count_out    number of completed frames, modulo 256
// ---------------------------------------------------------------------------
module serial_tx #(
   parameter int CLK_DIV   = 10,
   parameter int PARITY_EN = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] len_in,
   input  logic [7:0] data_in,
   input  logic       tx_ready_in,
   output logic       dequeue_out,
   output logic       serial_out,
   output logic       frame_active_out,
   output logic       tx_done_out,
   output logic [7:0] sent_count_out
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      GAP
   } state_t;

   // The divider counts down from CLK_DIV-1 to 0, so a bit spans CLK_DIV edges.
   localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
   localparam bit         HAS_PARITY = (PARITY_EN != 0);

   state_t     state_q;
   logic [7:0] shift_q;
   logic [7:0] divCnt_q;
   logic [2:0] bitCnt_q;
   logic       parity_q;
   logic       serial_q;
   logic       dequeue_q;
   logic       frameActive_q;
   logic       txDone_q;
   logic [7:0] sentCount_q;

   // Next values of the two flags that gate most transitions.
   logic       launch_d;
   logic       bitEnd_d;

   // A launch needs a non-empty queue and a willing downstream; bit
   // boundaries fall on the edge where the divider has run down to zero.
   always_comb begin
      launch_d = (len_in != 4'd0) && tx_ready_in;
      bitEnd_d = (divCnt_q == 8'd0);
   end

   // Frame sequencer. All outputs are registered here so the serial line and
   // handshake pulses change only on clock edges (or immediately on reset).
   // The parity bit is computed once from the captured byte at launch, so it
   // never depends on how far the shift register has advanced.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         shift_q       <= 8'h00;
         divCnt_q      <= 8'd0;
         bitCnt_q      <= 3'd0;
         parity_q      <= 1'b0;
         serial_q      <= 1'b1;
         dequeue_q     <= 1'b0;
         frameActive_q <= 1'b0;
         txDone_q      <= 1'b0;
         sentCount_q   <= 8'd0;
      end else begin
         dequeue_q <= 1'b0;
         txDone_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               serial_q      <= 1'b1;
               frameActive_q <= 1'b0;
               if (launch_d) begin
                  shift_q       <= data_in;
                  parity_q      <= ^data_in;
                  dequeue_q     <= 1'b1;
                  serial_q      <= 1'b0;
                  frameActive_q <= 1'b1;
                  divCnt_q      <= DIV_RELOAD;
                  bitCnt_q      <= 3'd0;
                  state_q       <= START;
               end
            end

            START: begin
               if (bitEnd_d) begin
                  divCnt_q <= DIV_RELOAD;
                  bitCnt_q <= 3'd0;
                  serial_q <= shift_q[0];
                  state_q  <= DATA;
               end else begin
                  divCnt_q <= divCnt_q - 8'd1;
               end
            end

            // The bit on the line is always shift_q[0]; the next one to send
            // is therefore shift_q[1] at the moment of the shift.
            DATA: begin
               if (bitEnd_d) begin
                  divCnt_q <= DIV_RELOAD;
                  if (bitCnt_q == 3'd7) begin
                     if (HAS_PARITY) begin
                        serial_q <= parity_q;
                        state_q  <= PARITY;
                     end else begin
                        serial_q <= 1'b1;
                        state_q  <= STOP;
                     end
                  end else begin
                     bitCnt_q <= bitCnt_q + 3'd1;
                     shift_q  <= {1'b0, shift_q[7:1]};
                     serial_q <= shift_q[1];
                  end
               end else begin
                  divCnt_q <= divCnt_q - 8'd1;
               end
            end

            PARITY: begin
               if (bitEnd_d) begin
                  divCnt_q <= DIV_RELOAD;
                  serial_q <= 1'b1;
                  state_q  <= STOP;
               end else begin
                  divCnt_q <= divCnt_q - 8'd1;
               end
            end

            STOP: begin
               if (bitEnd_d) begin
                  divCnt_q      <= 8'd0;
                  serial_q      <= 1'b1;
                  frameActive_q <= 1'b0;
                  txDone_q      <= 1'b1;
                  sentCount_q   <= sentCount_q + 8'd1;
                  state_q       <= GAP;
               end else begin
                  divCnt_q <= divCnt_q - 8'd1;
               end
            end

            // One dead cycle so the queue occupancy reflects the last pop.
            GAP: begin
               serial_q <= 1'b1;
               state_q  <= IDLE;
            end

            default: begin
               serial_q      <= 1'b1;
               frameActive_q <= 1'b0;
               state_q       <= IDLE;
            end
         endcase
      end
   end

   assign dequeue_out      = dequeue_q;
   assign serial_out       = serial_q;
   assign frame_active_out = frameActive_q;
   assign tx_done_out      = txDone_q;
   assign sent_count_out   = sentCount_q;

endmodule

// File: tb/tb_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_tx
// Drives serial_tx from a modelled upstream byte queue. Each issued byte has
// a hand-computed frame (bit pattern, sent count, spacing) pushed into an
// expectation queue; an independent monitor decodes every frame the DUT
// launches and compares it with the next queued expectation. A second
// instance with PARITY_EN=0 covers the parity-less frame format.
// ---------------------------------------------------------------------------
module tb_serial_tx;

   localparam int DIV   = 10;
   localparam int NBITS = 11;

   typedef struct packed {
      logic [10:0] bits;
      logic [7:0]  count;
      logic        backToBack;
      logic        expectAbort;
   } expFrame_t;

   logic       clock;
   logic       reset;
   logic [3:0] lenIn;
   logic [7:0] dataIn;
   logic       txReadyIn;
   logic       dequeueOut;
   logic       serialOut;
   logic       frameActiveOut;
   logic       txDoneOut;
   logic [7:0] sentCountOut;

   logic [3:0] lenNp;
   logic [7:0] dataNp;
   logic       readyNp;
   logic       dequeueNp;
   logic       serialNp;
   logic       frameActiveNp;
   logic       txDoneNp;
   logic [7:0] sentCountNp;

   int testsRun    = 0;
   int testsFailed = 0;
   int framesDone  = 0;

   logic [7:0] byteQ [$];
   expFrame_t  expQ  [$];

   expFrame_t  monExp;
   logic       monBad [NBITS];
   int         monCyc;
   int         monLastDone;
   int         monActiveErr;
   int         monDeqErr;
   bit         monAborted;

   serial_tx #(.CLK_DIV(DIV), .PARITY_EN(1)) dut (
      .clock            (clock),
      .reset            (reset),
      .len_in           (lenIn),
      .data_in          (dataIn),
      .tx_ready_in      (txReadyIn),
      .dequeue_out      (dequeueOut),
      .serial_out       (serialOut),
      .frame_active_out (frameActiveOut),
      .tx_done_out      (txDoneOut),
      .sent_count_out   (sentCountOut)
   );

   serial_tx #(.CLK_DIV(DIV), .PARITY_EN(0)) dutNp (
      .clock            (clock),
      .reset            (reset),
      .len_in           (lenNp),
      .data_in          (dataNp),
      .tx_ready_in      (readyNp),
      .dequeue_out      (dequeueNp),
      .serial_out       (serialNp),
      .frame_active_out (frameActiveNp),
      .tx_done_out      (txDoneNp),
      .sent_count_out   (sentCountNp)
   );

   // 100 MHz-style clock, period 10.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case something never completes.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: time limit reached after %0d tests", testsRun);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input longint actual, input longint required);
      testsRun++;
      if (actual != required) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, actual, required);
      end
   endtask

   task automatic updateInputs();
      lenIn  = 4'(byteQ.size());
      dataIn = (byteQ.size() != 0) ? byteQ[0] : 8'h00;
   endtask

   // Queue a byte upstream together with its hand-computed frame.
   task automatic applyStimulus(input logic [7:0] dataByte, input logic [10:0] bits,
                                input logic [7:0] count, input logic b2b, input logic abortExp);
      expFrame_t e;
      e.bits        = bits;
      e.count       = count;
      e.backToBack  = b2b;
      e.expectAbort = abortExp;
      byteQ.push_back(dataByte);
      expQ.push_back(e);
      updateInputs();
   endtask

   task automatic waitFrames(input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (framesDone >= target) return;
         @(negedge clock);
      end
      checkOutput("wait_frames", framesDone, target);
   endtask

   task automatic waitDequeue(output bit found);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (dequeueOut) begin
            found = 1'b1;
            return;
         end
      end
      checkOutput("wait_dequeue", found, 1);
   endtask

   // Upstream queue model: the head is popped at the end of the cycle in
   // which the DUT pulses dequeue_out.
   initial begin
      forever begin
         @(negedge clock);
         if (dequeueOut && !reset && byteQ.size() != 0) void'(byteQ.pop_front());
         updateInputs();
      end
   end

   // Frame monitor: decodes every launched frame cycle by cycle and checks
   // it, the GAP cycle and the spacing from the previous frame.
   initial begin
      monCyc      = 0;
      monLastDone = -100;
      forever begin
         @(negedge clock);
         monCyc++;
         if (reset) continue;
         if (txDoneOut) checkOutput("idle_tx_done", txDoneOut, 0);
         if (!dequeueOut) continue;
         if (expQ.size() == 0) begin
            checkOutput("unexpected_frame", expQ.size(), 1);
            monExp      = '0;
            monExp.bits = '1;
         end else begin
            monExp = expQ.pop_front();
         end
         if (monExp.backToBack) checkOutput("b2b_gap_cycles", monCyc - monLastDone, 2);
         monAborted   = 1'b0;
         monActiveErr = 0;
         monDeqErr    = 0;
         for (int b = 0; b < NBITS; b++) monBad[b] = monExp.bits[b];
         for (int c = 0; c < NBITS * DIV; c++) begin
            if (c > 0) begin
               @(negedge clock);
               monCyc++;
            end
            if (reset) begin
               monAborted = 1'b1;
               break;
            end
            if (serialOut !== monExp.bits[c / DIV] && monBad[c / DIV] === monExp.bits[c / DIV])
               monBad[c / DIV] = serialOut;
            if (frameActiveOut !== 1'b1) monActiveErr++;
            if (c > 0 && dequeueOut !== 1'b0) monDeqErr++;
         end
         if (!monAborted) begin
            @(negedge clock);
            monCyc++;
            if (reset) monAborted = 1'b1;
         end
         checkOutput("frame_aborted", monAborted, monExp.expectAbort);
         if (!monAborted) begin
            for (int b = 0; b < NBITS; b++)
               checkOutput($sformatf("frame%0d_bit%0d", framesDone, b), monBad[b], monExp.bits[b]);
            checkOutput("active_low_cycles", monActiveErr, 0);
            checkOutput("extra_dequeue", monDeqErr, 0);
            checkOutput("done_pulse", txDoneOut, 1);
            checkOutput("active_in_gap", frameActiveOut, 0);
            checkOutput("serial_in_gap", serialOut, 1);
            checkOutput("dequeue_in_gap", dequeueOut, 0);
            checkOutput("sent_count", sentCountOut, monExp.count);
            monLastDone = monCyc;
         end
         framesDone++;
      end
   end

   // Directed scenarios.
   initial begin
      logic [9:0] npBits;
      bit         found;
      int         errA;
      int         errB;

      npBits    = 10'b1_0000_0111_0;
      reset     = 1'b1;
      txReadyIn = 1'b1;
      lenIn     = 4'd0;
      dataIn    = 8'h00;
      lenNp     = 4'd0;
      dataNp    = 8'h00;
      readyNp   = 1'b1;

      repeat (3) @(negedge clock);
      checkOutput("reset_serial", serialOut, 1);
      checkOutput("reset_dequeue", dequeueOut, 0);
      checkOutput("reset_active", frameActiveOut, 0);
      checkOutput("reset_done", txDoneOut, 0);
      checkOutput("reset_count", sentCountOut, 0);
      reset = 1'b0;

      // Parity-less instance: 0x07 gives a 10-bit, 100-cycle frame.
      lenNp  = 4'd1;
      dataNp = 8'h07;
      found  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (dequeueNp) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("np_launch", found, 1);
      lenNp = 4'd0;
      if (found) begin
         errA = 0;
         errB = 0;
         for (int c = 0; c < 100; c++) begin
            if (c > 0) @(negedge clock);
            if (serialNp !== npBits[c / 10]) errA++;
            if (txDoneNp) errB++;
         end
         @(negedge clock);
         checkOutput("np_bit_errors", errA, 0);
         checkOutput("np_early_done", errB, 0);
         checkOutput("np_done_at_100", txDoneNp, 1);
         checkOutput("np_count", sentCountNp, 1);
      end

      // Single frames: 0xA5 (parity 0) and 0x07 (parity 1).
      applyStimulus(8'hA5, 11'b1_0_1010_0101_0, 8'd1, 1'b0, 1'b0);
      waitFrames(1, 150);
      applyStimulus(8'h07, 11'b1_1_0000_0111_0, 8'd2, 1'b0, 1'b0);
      waitFrames(2, 150);

      // Empty queue for 500 cycles: line stays idle, no pops.
      errA = 0;
      errB = 0;
      repeat (500) begin
         @(negedge clock);
         if (dequeueOut) errA++;
         if (serialOut !== 1'b1) errB++;
      end
      checkOutput("empty_dequeues", errA, 0);
      checkOutput("empty_serial_low", errB, 0);

      // Clear the count, then three queued bytes go out back to back.
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("pulse_reset_count", sentCountOut, 0);
      reset = 1'b0;
      applyStimulus(8'h12, 11'b1_0_0001_0010_0, 8'd1, 1'b0, 1'b0);
      applyStimulus(8'h34, 11'b1_1_0011_0100_0, 8'd2, 1'b1, 1'b0);
      applyStimulus(8'h56, 11'b1_0_0101_0110_0, 8'd3, 1'b1, 1'b0);
      waitFrames(5, 450);

      // Drop tx_ready 30 cycles into a frame: it completes, the next waits.
      applyStimulus(8'hFF, 11'b1_0_1111_1111_0, 8'd4, 1'b0, 1'b0);
      applyStimulus(8'h80, 11'b1_1_1000_0000_0, 8'd5, 1'b0, 1'b0);
      waitDequeue(found);
      repeat (30) @(negedge clock);
      txReadyIn = 1'b0;
      waitFrames(6, 150);
      errA = 0;
      repeat (40) begin
         @(negedge clock);
         if (dequeueOut) errA++;
      end
      checkOutput("launch_while_not_ready", errA, 0);
      txReadyIn = 1'b1;
      waitFrames(7, 150);

      // Reset in the middle of DATA aborts the frame at once.
      applyStimulus(8'hC3, 11'b1_0_1100_0011_0, 8'd0, 1'b0, 1'b1);
      waitDequeue(found);
      repeat (25) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      checkOutput("abort_serial", serialOut, 1);
      checkOutput("abort_active", frameActiveOut, 0);
      checkOutput("abort_count", sentCountOut, 0);
      checkOutput("abort_done", txDoneOut, 0);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      waitFrames(8, 20);
      repeat (20) @(negedge clock);
      checkOutput("after_abort_count", sentCountOut, 0);

      // 255 frames to preload the counter, then one more wraps it to 0.
      for (int i = 1; i <= 256; i++) begin
         applyStimulus(8'h3C, 11'b1_0_0011_1100_0, 8'(i), 1'b0, 1'b0);
         waitFrames(8 + i, 150);
      end
      checkOutput("wrap_count_final", sentCountOut, 0);

      repeat (5) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter CLK_DIV, default 10: number of clock cycles each serial bit is held; legal range is 2..255.
REQ-002 Parameter PARITY_EN, default 1: 1 inserts an even-parity bit after the data bits; 0 omits it.
REQ-003 clock  input  1  system clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 len_in  input  4  upstream queue occupancy, synchronous to clock; 0 means empty.
REQ-006 data_in  input  8  upstream queue head byte; valid whenever len_in != 0.
REQ-007 tx_ready_in  input  1  downstream can accept a new frame.
REQ-008 dequeue_out  output  1  one-cycle pop pulse to the upstream queue.
REQ-009 serial_out  output  1  serial line; idles high.
REQ-010 frame_active_out  output  1  high from the start bit through the last stop-bit cycle.
REQ-011 tx_done_out  output  1  one-cycle pulse marking completion of a frame.
REQ-012 sent_count_out  output  8  count of completed frames.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP and GAP, all registered.
REQ-014 In IDLE, a frame SHALL launch at a rising edge where len_in != 0 and tx_ready_in = 1; otherwise the FSM SHALL remain in IDLE.
- REQ-015 At the launch edge the block SHALL:
  - capture data_in into an 8-bit shift register;
  - set dequeue_out = 1 for exactly that one cycle;
  - drive serial_out = 0;
  - set frame_active_out = 1;
  - enter START.
REQ-016 Each bit SHALL be held for exactly CLK_DIV cycles, timed by a divider counter that reloads on every bit boundary.
REQ-017 START SHALL hold 0; DATA SHALL send 8 bits LSB first; PARITY (only when PARITY_EN = 1) SHALL send the XOR of the 8 captured bits; STOP SHALL hold 1.
REQ-018 Total frame length SHALL be (10 + PARITY_EN) * CLK_DIV cycles, measured from the launch edge to the edge entering GAP.
REQ-019 On entering GAP the block SHALL pulse tx_done_out for one cycle, clear frame_active_out, and increment sent_count_out modulo 256 (255 wraps to 0).
REQ-020 GAP SHALL last exactly one cycle and then return to IDLE, so that len_in reflects the preceding pop before the next launch decision.
REQ-021 len_in, data_in and tx_ready_in SHALL be ignored outside IDLE; deassertion of tx_ready_in mid-frame SHALL NOT abort the frame.
REQ-022 dequeue_out SHALL never assert while len_in = 0, and SHALL assert at most once per frame.
REQ-023 Back-to-back frames SHALL be separated by exactly 2 cycles of serial_out = 1 (GAP plus IDLE).
REQ-024 The shift register SHALL not change between launch and GAP except by its own right shift.

Reset
REQ-025 While reset = 1 the outputs SHALL be: serial_out = 1, dequeue_out = 0, frame_active_out = 0, tx_done_out = 0, sent_count_out = 0, state = IDLE, divider and bit counters = 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously), without a tx_done_out pulse and without a further dequeue.
REQ-027 After reset deasserts, the first launch SHALL occur no earlier than the first rising edge at which the REQ-014 conditions hold.

Verification
REQ-028 CLK_DIV=10, PARITY_EN=1, len_in=1, data_in=0xA5, tx_ready_in=1 -> SHALL observe:
- dequeue_out high for 1 cycle;
- serial_out sequence 0,1,0,1,0,0,1,0,1,0,1, each bit held 10 cycles;
- tx_done_out pulse 110 cycles after launch;
- sent_count_out = 1.
REQ-029 data_in=0x07, PARITY_EN=1 -> parity bit = 1; with PARITY_EN=0 -> no parity bit, and the frame SHALL be 100 cycles.
REQ-030 len_in=0 for 500 cycles with tx_ready_in=1 -> dequeue_out SHALL stay 0 and serial_out SHALL stay 1 throughout.
REQ-031 len_in=3, tx_ready_in=1 throughout -> SHALL observe 3 frames, 3 dequeue pulses, each inter-frame idle exactly 2 cycles, and sent_count_out = 3.
REQ-032 tx_ready_in dropped at cycle 30 of a frame -> the frame SHALL complete; no new launch SHALL occur until tx_ready_in returns to 1.
REQ-033 Reset pulsed during DATA -> serial_out = 1 and frame_active_out = 0 SHALL hold immediately, sent_count_out = 0, with no tx_done_out pulse.
REQ-034 Preload 255 completed frames, then send one more -> sent_count_out SHALL wrap to 0.
